// File: rtl/led_mmio_slave.sv
// Memory-mapped LED peripheral: 16-byte register window with set/clear aliases,
// a single-outstanding-request handshake and a prescaled blink engine.
module led_mmio_slave #(
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter int unsigned CNT_W     = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ready,
   output logic [31:0] bus_rdata,
   output logic [7:0]  led
);

   typedef enum logic {S_IDLE, S_RESP} state_e;

   localparam logic [1:0]       A_DATA   = 2'd0;
   localparam logic [1:0]       A_SET    = 2'd1;
   localparam logic [1:0]       A_CLR    = 2'd2;
   localparam logic [1:0]       A_CTRL   = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [7:0]        led_q, led_d;
   logic [7:0]        data_q, data_d;
   logic              en_q, en_d;
   logic [7:0]        mask_q, mask_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic              commit_c, wr_c;
   logic [1:0]        sel_c;
   logic              unused_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next state: one response cycle per accepted request
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus_valid) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Register file, read capture and blink engine next-state
   always_comb begin
      commit_c = (state_q == S_IDLE) && bus_valid;
      wr_c     = commit_c && bus_we;
      sel_c    = bus_addr[3:2];
      ready_d  = commit_c;
      rdata_d  = '0;
      data_d   = data_q;
      en_d     = en_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;

      if (wr_c) begin
         case (sel_c)
            A_DATA:  data_d = bus_wdata[7:0];
            A_SET:   data_d = data_q | bus_wdata[7:0];
            A_CLR:   data_d = data_q & ~bus_wdata[7:0];
            default: begin
               en_d   = bus_wdata[0];
               mask_d = bus_wdata[15:8];
            end
         endcase
      end

      if (commit_c && !bus_we) begin
         if (sel_c == A_CTRL) rdata_d = {16'h0, mask_q, 7'h0, en_q};
         else                 rdata_d = {24'h0, data_q};
      end

      // A CTRL write restarts the blink period even if a wrap lands on the same edge
      if ((wr_c && sel_c == A_CTRL) || !en_q) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
      end

      // Built from next-state values so a data write shows up alongside bus_ready
      led_d = data_d ^ ({8{phase_d}} & mask_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         led_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         mask_q  <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         led_q   <= led_d;
         data_q  <= data_d;
         en_q    <= en_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign unused_c  = ^{bus_addr[1:0], bus_wdata[31:16]};
   assign bus_ready = ready_q;
   assign bus_rdata = rdata_q;
   assign led       = led_q;

endmodule

// File: tb/tb_led_mmio_slave.sv
// Directed bench for led_mmio_slave: scoreboarded bus accesses, blink timing and resets.
module tb_led_mmio_slave;

   localparam int unsigned BLINK_DIV = 4;
   localparam int unsigned CNT_W     = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bus_valid = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [7:0]  led;

   typedef struct {
      logic        is_rd;
      logic [31:0] rdata;
      logic [7:0]  led;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_fail = 0;

   led_mmio_slave #(.BLINK_DIV(BLINK_DIV), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata), .led(led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request (called just after a rising edge); hold keeps valid high for a follow-on
   task automatic access(input string tag, input logic we, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic [7:0] exp_led, input bit hold);
      exp_t e;
      int   n;
      bit   seen;
      sb_q.push_back('{is_rd: !we, rdata: exp_rdata, led: exp_led});
      bus_valid = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (bus_ready === 1'b1) seen = 1'b1;
      end
      check({tag, "_ready"}, 32'(seen), 32'd1);
      e = sb_q.pop_front();
      if (seen) begin
         check({tag, "_latency"}, 32'(n), 32'd2);
         if (e.is_rd) check({tag, "_rdata"}, bus_rdata, e.rdata);
         check({tag, "_led"}, 32'(led), 32'(e.led));
      end
      @(posedge clk);
      #1;
      if (!hold) bus_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Power-on reset
      #12;
      check("por_led", 32'(led), 32'h0);
      check("por_ready", 32'(bus_ready), 32'h0);
      check("por_rdata", bus_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: asynchronous reset mid-simulation, then a plain data write
      access("t1_pre", 1'b1, 4'h0, 32'h0000_003C, 32'h0, 8'h3C, 1'b0);
      #3 rst = 1'b0;
      #1;
      check("t1_rst_led", 32'(led), 32'h0);
      check("t1_rst_ready", 32'(bus_ready), 32'h0);
      check("t1_rst_rdata", bus_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      access("t1_wr", 1'b1, 4'h0, 32'h0000_00A5, 32'h0, 8'hA5, 1'b0);

      // T2: set/clear aliases and readback
      access("t2_data", 1'b1, 4'h0, 32'h0000_00A0, 32'h0, 8'hA0, 1'b0);
      access("t2_set",  1'b1, 4'h4, 32'h0000_000F, 32'h0, 8'hAF, 1'b0);
      access("t2_clr",  1'b1, 4'h8, 32'h0000_0081, 32'h0, 8'h2E, 1'b0);
      access("t2_rd0",  1'b0, 4'h0, 32'h0, 32'h0000_002E, 8'h2E, 1'b0);
      access("t2_rdset", 1'b0, 4'h7, 32'h0, 32'h0000_002E, 8'h2E, 1'b0);

      // T3: blink with a half-period of BLINK_DIV cycles
      access("t3_data", 1'b1, 4'h0, 32'h0000_000F, 32'h0, 8'h0F, 1'b0);
      access("t3_ctrl", 1'b1, 4'hC, 32'h0000_F001, 32'h0, 8'h0F, 1'b0);
      for (int i = 1; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("t3_blink%0d", i), 32'(led), ((i / 4) % 2 == 1) ? 32'hFF : 32'h0F);
      end
      @(posedge clk); #1;
      access("t3_off", 1'b1, 4'hC, 32'h0, 32'h0, 8'h0F, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("t3_steady%0d", i), 32'(led), 32'h0F);
      end
      @(posedge clk); #1;

      // T4: back-to-back writes with valid held, then CTRL readback
      access("t4_wr0", 1'b1, 4'h0, 32'h0000_0011, 32'h0, 8'h11, 1'b1);
      access("t4_set", 1'b1, 4'h4, 32'h0000_0022, 32'h0, 8'h33, 1'b0);
      access("t4_ctrl_wr", 1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0, 8'h33, 1'b0);
      access("t4_ctrl_rd", 1'b0, 4'hC, 32'h0, 32'h0000_FF01, 8'h33, 1'b0);
      // This CTRL write commits on the same edge as a prescaler wrap
      access("t4_ctrl_off", 1'b1, 4'hC, 32'h0, 32'h0, 8'h33, 1'b0);
      @(negedge clk);
      check("t4_led_final", 32'(led), 32'h33);
      @(posedge clk); #1;

      // T5: reset during the response cycle of a write
      bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h0000_0055;
      @(negedge clk);
      @(negedge clk);
      check("t5_ready_before", 32'(bus_ready), 32'h1);
      check("t5_led_before", 32'(led), 32'h55);
      #1 rst = 1'b0;
      #1;
      check("t5_ready_rst", 32'(bus_ready), 32'h0);
      check("t5_led_rst", 32'(led), 32'h0);
      bus_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      access("t5_rd_after", 1'b0, 4'h0, 32'h0, 32'h0, 8'h00, 1'b0);
      access("t5_wr_wide", 1'b1, 4'h0, 32'hDEAD_BEA5, 32'h0, 8'hA5, 1'b0);
      access("t5_rd_wide", 1'b0, 4'h0, 32'h0, 32'h0000_00A5, 8'hA5, 1'b0);
      access("t5_rd_ctrl", 1'b0, 4'hC, 32'h0, 32'h0, 8'hA5, 1'b0);
      check("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
